// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared definitions for the counter sequencing controller.
// Holds the FSM state encoding, the counter terminal values and the
// default prescaler dividers.
package count_seq_pkg;

   // FSM state encoding (typed constants kept for legacy tool compatibility)
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_LOAD  = 3'd1;
   localparam state_t ST_RUN   = 3'd2;
   localparam state_t ST_PAUSE = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

   // Counter terminal values: binary low byte, BCD high byte
   localparam logic [15:0] TERM_UP = 16'h99FF;
   localparam logic [15:0] TERM_DN = 16'h0000;

   // Default dividers in clk cycles
   localparam int TICK_DIV_DEF  = 1000;
   localparam int BLINK_DIV_DEF = 500;

endpackage

// File: rtl/count_seq_ctrl_if.sv
// count_seq_ctrl_if: control/status bus between the sequencing controller
// (master) and the 16-bit up/down/load counter (slave).
interface count_seq_ctrl_if;

   logic        cnt_up;
   logic        cnt_dw;
   logic        cnt_ld;
   logic [15:0] cnt_din;
   logic        cnt_utc;
   logic        cnt_dtc;

   modport master (
      output cnt_up, cnt_dw, cnt_ld, cnt_din,
      input  cnt_utc, cnt_dtc
   );

   modport slave (
      input  cnt_up, cnt_dw, cnt_ld, cnt_din,
      output cnt_utc, cnt_dtc
   );

endinterface

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler. Counts 0..DIV-1 while enabled, holds
// while disabled, and asserts tick_o in the cycle the count equals DIV-1
// (the count wraps to 0 on the following edge). clr_i wins over en_i.
module tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int          W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign tick_o = en_i & (cnt_q == LAST);

   // Next prescaler count: clear, wrap on tick, advance while enabled
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {W{1'b0}};
      end else if (tick_o) begin
         cnt_d = {W{1'b0}};
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Prescaler count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: turns start/stop/load buttons into single-cycle counter
// controls, paces counting with a tick prescaler and flags terminal count.
// Optional feature macro: COUNT_SEQ_AUTO_RELOAD_EN -- when defined, a
// terminal count reloads the stored preset and keeps running instead of
// entering DONE (done then pulses for one cycle and blink stays 0).
module count_seq_ctrl
   import count_seq_pkg::*;
#(
   parameter int TICK_DIV  = TICK_DIV_DEF,
   parameter int BLINK_DIV = BLINK_DIV_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_btn,
   input  logic                    stop_btn,
   input  logic                    load_btn,
   input  logic                    dir_up,
   input  logic [15:0]             preset,
   count_seq_ctrl_if.master        cnt_bus,
   output logic                    running,
   output logic                    done,
   output logic                    blink
);

   // Divider legality is checked when the design is elaborated
   if (TICK_DIV < 4) begin : g_bad_tick_div
      $error("count_seq_ctrl: TICK_DIV must be >= 4");
   end
   if (BLINK_DIV < 1) begin : g_bad_blink_div
      $error("count_seq_ctrl: BLINK_DIV must be >= 1");
   end

   logic        start_q, stop_q, load_q;
   logic        start_ev_s, stop_ev_s, load_ev_s;
   state_t      state_q, state_d;
   logic        up_q, up_d, dw_q, dw_d, ld_q, ld_d;
   logic [15:0] din_q, din_d;
   logic        running_q, running_d, done_q, done_d, blink_q, blink_d;
   logic        tick_s, pre_en_s, pre_clr_s, term_s, reload_s;

   assign start_ev_s = start_btn & ~start_q;
   assign stop_ev_s  = stop_btn  & ~stop_q;
   assign load_ev_s  = load_btn  & ~load_q;
   assign term_s     = dir_up ? cnt_bus.cnt_utc : cnt_bus.cnt_dtc;
   assign pre_en_s   = (state_q == ST_RUN);

   tick_gen #(.DIV(TICK_DIV)) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (pre_en_s),
      .clr_i  (pre_clr_s),
      .tick_o (tick_s)
   );

   // FSM next state and counter-command decode; load beats stop beats start
   always_comb begin
      state_d   = state_q;
      up_d      = 1'b0;
      dw_d      = 1'b0;
      din_d     = din_q;
      reload_s  = 1'b0;
      pre_clr_s = 1'b0;
      if (load_ev_s) begin
         state_d = ST_LOAD;
         din_d   = preset;
      end else begin
         case (state_q)
            ST_IDLE, ST_PAUSE: begin
               if (start_ev_s && !stop_ev_s) begin
                  state_d   = ST_RUN;
                  pre_clr_s = 1'b1;
               end else begin
                  state_d = state_q;
               end
            end
            ST_LOAD: state_d = ST_IDLE;
            ST_RUN: begin
               if (stop_ev_s) begin
                  state_d = ST_PAUSE;
               end else if (tick_s) begin
                  if (term_s) begin
`ifdef COUNT_SEQ_AUTO_RELOAD_EN
                     reload_s  = 1'b1;
                     pre_clr_s = 1'b1;
`else
                     state_d   = ST_DONE;
`endif
                  end else if (dir_up) begin
                     up_d = 1'b1;
                  end else begin
                     dw_d = 1'b1;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            ST_DONE: begin
               if (stop_ev_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = state_q;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Registered outputs derived from the upcoming state
   always_comb begin
      ld_d      = (state_d == ST_LOAD) | reload_s;
      done_d    = (state_d == ST_DONE) | reload_s;
      running_d = (state_d == ST_RUN);
   end

`ifdef COUNT_SEQ_AUTO_RELOAD_EN
   assign blink_d = 1'b0;
`else
   logic blink_en_s, blink_clr_s, blink_tick_s;

   assign blink_en_s  = (state_q == ST_DONE);
   assign blink_clr_s = (state_d == ST_DONE) & (state_q != ST_DONE);

   tick_gen #(.DIV(BLINK_DIV)) u_blink_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (blink_en_s),
      .clr_i  (blink_clr_s),
      .tick_o (blink_tick_s)
   );

   // Blink toggles on each blink-timer tick while DONE, forced low elsewhere
   always_comb begin
      if (state_d != ST_DONE) begin
         blink_d = 1'b0;
      end else if (blink_tick_s) begin
         blink_d = ~blink_q;
      end else begin
         blink_d = blink_q;
      end
   end
`endif

   // State, button history and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q   <= 1'b0;
         stop_q    <= 1'b0;
         load_q    <= 1'b0;
         state_q   <= ST_IDLE;
         up_q      <= 1'b0;
         dw_q      <= 1'b0;
         ld_q      <= 1'b0;
         din_q     <= 16'h0000;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         blink_q   <= 1'b0;
      end else begin
         start_q   <= start_btn;
         stop_q    <= stop_btn;
         load_q    <= load_btn;
         state_q   <= state_d;
         up_q      <= up_d;
         dw_q      <= dw_d;
         ld_q      <= ld_d;
         din_q     <= din_d;
         running_q <= running_d;
         done_q    <= done_d;
         blink_q   <= blink_d;
      end
   end

   assign cnt_bus.cnt_up  = up_q;
   assign cnt_bus.cnt_dw  = dw_q;
   assign cnt_bus.cnt_ld  = ld_q;
   assign cnt_bus.cnt_din = din_q;
   assign running         = running_q;
   assign done            = done_q;
   assign blink           = blink_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed scenarios plus a randomized run compared
// cycle by cycle against a behavioural model of the controller. A small
// model of the BCD/binary counter closes the loop on the terminal flags.
module tb_count_seq_ctrl;
   import count_seq_pkg::*;

   localparam int TD    = 4;
   localparam int BD    = 3;
   localparam int N_MAX = 25599;   // 99FF as a linear count
`ifdef COUNT_SEQ_AUTO_RELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif
   localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_btn, stop_btn, load_btn, dir_up;
   logic [15:0] preset;
   logic        running, done, blink;
   int          n_checks = 0;
   int          n_fail = 0;

   count_seq_ctrl_if bus ();

   count_seq_ctrl #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_btn (start_btn),
      .stop_btn  (stop_btn),
      .load_btn  (load_btn),
      .dir_up    (dir_up),
      .preset    (preset),
      .cnt_bus   (bus),
      .running   (running),
      .done      (done),
      .blink     (blink)
   );

   always #5 clk = ~clk;

   // ---------------- counter model (environment) ----------------
   int cnt_n = 0;
   bit wrap_err = 1'b0;

   function automatic int q_to_n(logic [15:0] q);
      return (int'(q[15:12]) * 10 + int'(q[11:8])) * 256 + int'(q[7:0]);
   endfunction

   function automatic logic [15:0] n_to_q(int n);
      int hi;
      hi = n / 256;
      return {4'(hi / 10), 4'(hi % 10), 8'(n % 256)};
   endfunction

   assign bus.cnt_utc = (n_to_q(cnt_n) == TERM_UP);
   assign bus.cnt_dtc = (n_to_q(cnt_n) == TERM_DN);

   always @(posedge clk) begin
      if (bus.cnt_ld) begin
         cnt_n <= q_to_n(bus.cnt_din);
      end else if (bus.cnt_up) begin
         if (cnt_n == N_MAX) wrap_err <= 1'b1;
         cnt_n <= (cnt_n == N_MAX) ? 0 : cnt_n + 1;
      end else if (bus.cnt_dw) begin
         if (cnt_n == 0) wrap_err <= 1'b1;
         cnt_n <= (cnt_n == 0) ? N_MAX : cnt_n - 1;
      end
   end

   // ---------------- controller reference model ----------------
   int          m_mode = M_IDLE, m_age = 0, m_dage = 0;
   logic [15:0] m_din = 16'h0000;
   bit          m_up = 0, m_dw = 0, m_rl = 0, m_ps = 0, m_pp = 0, m_pl = 0;
   int          cyc = 0;

   function automatic logic [21:0] model_out();
      bit b;
      b = (m_mode == M_DONE) && (((m_dage / BD) % 2) == 1);
      return {m_up, m_dw, (m_mode == M_LOAD) || m_rl, m_mode == M_RUN,
              (m_mode == M_DONE) || m_rl, b, m_din};
   endfunction

   function automatic logic [21:0] dut_out();
      return {bus.cnt_up, bus.cnt_dw, bus.cnt_ld, running, done, blink, bus.cnt_din};
   endfunction

   // advance one clock, predicting the controller outputs for the next cycle
   task automatic clk_step();
      int          n_mode, n_age, n_dage;
      logic [15:0] n_din;
      bit          n_up, n_dw, n_rl, ev_s, ev_p, ev_l, tick, term, n_ps, n_pp, n_pl;
      n_mode = M_IDLE; n_age = 0; n_dage = 0; n_din = 16'h0000;
      n_up = 0; n_dw = 0; n_rl = 0; n_ps = 0; n_pp = 0; n_pl = 0;
      if (rst_n) begin
         ev_s = start_btn && !m_ps;
         ev_p = stop_btn && !m_pp;
         ev_l = load_btn && !m_pl;
         n_ps = start_btn; n_pp = stop_btn; n_pl = load_btn;
         tick = (m_mode == M_RUN) && ((m_age % TD) == TD - 1);
         term = dir_up ? (cnt_n == N_MAX) : (cnt_n == 0);
         n_mode = m_mode;
         n_age  = (m_mode == M_RUN) ? m_age + 1 : m_age;
         n_din  = m_din;
         if (ev_l) begin
            n_mode = M_LOAD;
            n_din  = preset;
         end else if ((m_mode == M_IDLE || m_mode == M_PAUSE) && ev_s && !ev_p) begin
            n_mode = M_RUN;
            n_age  = 0;
         end else if (m_mode == M_LOAD) begin
            n_mode = M_IDLE;
         end else if (m_mode == M_RUN && ev_p) begin
            n_mode = M_PAUSE;
         end else if (m_mode == M_RUN && tick) begin
            if (term && AUTO) begin
               n_rl = 1; n_age = 0;
            end else if (term) begin
               n_mode = M_DONE;
            end else if (dir_up) begin
               n_up = 1;
            end else begin
               n_dw = 1;
            end
         end else if (m_mode == M_DONE && ev_p) begin
            n_mode = M_IDLE;
         end
         n_dage = (n_mode == M_DONE && m_mode == M_DONE) ? m_dage + 1 : 0;
      end
      @(posedge clk);
      #1;
      m_mode = n_mode; m_age = n_age; m_dage = n_dage; m_din = n_din;
      m_up = n_up; m_dw = n_dw; m_rl = n_rl; m_ps = n_ps; m_pp = n_pp; m_pl = n_pl;
      cyc++;
   endtask

   // load a preset through the controller and return to IDLE
   task automatic do_load(input logic [15:0] val);
      preset = val; load_btn = 1'b1; clk_step();
      load_btn = 1'b0; clk_step();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      start_btn = 0; stop_btn = 0; load_btn = 0; dir_up = 0; preset = 16'h0000;
      rst_n = 1'b0;
      clk_step(); clk_step();
      n_checks++;
      if (dut_out() !== 22'h0) begin
         n_fail++; $display("FAIL reset_hold got=%h exp=%h", dut_out(), 22'h0);
      end
      rst_n = 1'b1;
      clk_step();
      n_checks++;
      if (dut_out() !== 22'h0) begin
         n_fail++; $display("FAIL reset_idle got=%h exp=%h", dut_out(), 22'h0);
      end
   endtask

   task automatic test_load_count_down();
      preset = 16'h1205; load_btn = 1'b1; clk_step();
      n_checks++;
      if ({bus.cnt_ld, bus.cnt_din} !== {1'b1, 16'h1205}) begin
         n_fail++; $display("FAIL load_pulse got ld=%b din=%h exp ld=1 din=1205", bus.cnt_ld, bus.cnt_din);
      end
      load_btn = 1'b0; clk_step();
      n_checks++;
      if (bus.cnt_ld !== 1'b0 || n_to_q(cnt_n) !== 16'h1205) begin
         n_fail++; $display("FAIL load_once got ld=%b q=%h exp ld=0 q=1205", bus.cnt_ld, n_to_q(cnt_n));
      end
      dir_up = 1'b0; start_btn = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         bit exp_dw;
         clk_step();
         start_btn = 1'b0;
         exp_dw = (k >= 5) && (((k - 5) % 4) == 0);
         n_checks++;
         if ({bus.cnt_up, bus.cnt_dw, running} !== {1'b0, exp_dw, 1'b1}) begin
            n_fail++; $display("FAIL down_pace k=%0d got up/dw/run=%b%b%b exp=0%b1", k, bus.cnt_up, bus.cnt_dw, running, exp_dw);
         end
      end
      n_checks++;
      if (n_to_q(cnt_n) !== 16'h1202) begin
         n_fail++; $display("FAIL down_value got=%h exp=1202", n_to_q(cnt_n));
      end
      stop_btn = 1'b1; clk_step();
      n_checks++;
      if (running !== 1'b0) begin
         n_fail++; $display("FAIL stop_pause got running=%b exp=0", running);
      end
      stop_btn = 1'b0; clk_step();
   endtask

   task automatic test_start_stop_edges();
      int entries = 0;
      bit prev = 0;
      start_btn = 1'b1; stop_btn = 1'b1; clk_step();
      clk_step(); clk_step();
      n_checks++;
      if ({running, done} !== 2'b00) begin
         n_fail++; $display("FAIL start_stop_same got run/done=%b%b exp=00", running, done);
      end
      start_btn = 1'b0; stop_btn = 1'b0; clk_step();
      start_btn = 1'b1;
      for (int i = 0; i < 100; i++) begin
         clk_step();
         if (running && !prev) entries++;
         prev = running;
      end
      n_checks++;
      if (entries !== 1 || running !== 1'b1) begin
         n_fail++; $display("FAIL held_start got entries=%0d running=%b exp entries=1 running=1", entries, running);
      end
      start_btn = 1'b0; stop_btn = 1'b1; clk_step();
      stop_btn = 1'b0; clk_step();
   endtask

   task automatic test_reset_mid_run();
      int held;
      start_btn = 1'b1; clk_step(); start_btn = 1'b0;
      repeat (10) clk_step();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (dut_out() !== 22'h0) begin
         n_fail++; $display("FAIL async_reset got=%h exp=%h", dut_out(), 22'h0);
      end
      held = cnt_n;
      clk_step();
      rst_n = 1'b1; clk_step();
      n_checks++;
      if (cnt_n !== held || running !== 1'b0) begin
         n_fail++; $display("FAIL reset_keeps_q got n=%0d run=%b exp n=%0d run=0", cnt_n, running, held);
      end
      dir_up = 1'b0; start_btn = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         clk_step();
         start_btn = 1'b0;
      end
      n_checks++;
      if (cnt_n !== held - 1 || running !== 1'b1) begin
         n_fail++; $display("FAIL resume_count got n=%0d run=%b exp n=%0d run=1", cnt_n, running, held - 1);
      end
      stop_btn = 1'b1; clk_step(); stop_btn = 1'b0; clk_step();
   endtask

`ifndef COUNT_SEQ_AUTO_RELOAD_EN
   task automatic test_down_terminal();
      do_load(16'h0000);
      dir_up = 1'b0; start_btn = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         clk_step();
         start_btn = 1'b0;
         n_checks++;
         if ({bus.cnt_dw, done, blink} !== {1'b0, k == 5, 1'b0}) begin
            n_fail++; $display("FAIL dtc_done k=%0d got dw/done/blink=%b%b%b exp=0%b0", k, bus.cnt_dw, done, blink, k == 5);
         end
      end
      for (int j = 1; j <= 4 * BD; j++) begin
         clk_step();
         start_btn = (j == 2);
         n_checks++;
         if ({done, blink} !== {1'b1, ((j / BD) % 2) == 1}) begin
            n_fail++; $display("FAIL blink j=%0d got done/blink=%b%b exp=1%b", j, done, blink, ((j / BD) % 2) == 1);
         end
      end
      start_btn = 1'b0; stop_btn = 1'b1; clk_step();
      n_checks++;
      if ({done, blink, running} !== 3'b000) begin
         n_fail++; $display("FAIL done_ack got done/blink/run=%b%b%b exp=000", done, blink, running);
      end
      stop_btn = 1'b0; clk_step();
   endtask

   task automatic test_up_terminal();
      do_load(16'h99FE);
      dir_up = 1'b1; start_btn = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         clk_step();
         start_btn = 1'b0;
         n_checks++;
         if ({bus.cnt_up, done} !== {k == 5, k >= 9}) begin
            n_fail++; $display("FAIL utc_done k=%0d got up/done=%b%b exp=%b%b", k, bus.cnt_up, done, k == 5, k >= 9);
         end
      end
      n_checks++;
      if (n_to_q(cnt_n) !== 16'h99FF || wrap_err !== 1'b0) begin
         n_fail++; $display("FAIL no_wrap got q=%h wrap=%b exp q=99ff wrap=0", n_to_q(cnt_n), wrap_err);
      end
      stop_btn = 1'b1; clk_step(); stop_btn = 1'b0; clk_step();
   endtask
`else
   task automatic test_auto_reload();
      do_load(16'h0002);
      dir_up = 1'b0; start_btn = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         bit e_dw;
         clk_step();
         start_btn = 1'b0;
         e_dw = (k == 5) || (k == 9) || (k == 17);
         n_checks++;
         if ({bus.cnt_up, bus.cnt_dw, bus.cnt_ld, done, running} !== {1'b0, e_dw, k == 13, k == 13, 1'b1}) begin
            n_fail++; $display("FAIL auto_reload k=%0d got up/dw/ld/done/run=%b%b%b%b%b exp=0%b%b%b1", k,
                               bus.cnt_up, bus.cnt_dw, bus.cnt_ld, done, running, e_dw, k == 13, k == 13);
         end
      end
      n_checks++;
      if (cnt_n !== 1 || wrap_err !== 1'b0) begin
         n_fail++; $display("FAIL auto_value got n=%0d wrap=%b exp n=1 wrap=0", cnt_n, wrap_err);
      end
      stop_btn = 1'b1; clk_step(); stop_btn = 1'b0; clk_step();
   endtask
`endif

   task automatic test_random();
      int n;
      start_btn = 0; stop_btn = 0; load_btn = 0;
      rst_n = 1'b0; clk_step(); clk_step();
      rst_n = 1'b1; clk_step();
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 5) == 0)  start_btn = ~start_btn;
         if ($urandom_range(0, 11) == 0) stop_btn  = ~stop_btn;
         if ($urandom_range(0, 39) == 0) load_btn  = ~load_btn;
         if ($urandom_range(0, 49) == 0) dir_up    = ~dir_up;
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 4))
               0:       n = 2;
               1:       n = N_MAX - 1;
               2:       n = 0;
               3:       n = N_MAX;
               default: n = int'($urandom_range(0, N_MAX));
            endcase
            preset = n_to_q(n);
         end
         clk_step();
         n_checks++;
         if (dut_out() !== model_out()) begin
            n_fail++; $display("FAIL random cyc=%0d got up,dw,ld,run,done,blink,din=%b exp=%b", cyc, dut_out(), model_out());
         end
      end
      n_checks++;
      if (wrap_err !== 1'b0) begin
         n_fail++; $display("FAIL random_wrap got=%b exp=0", wrap_err);
      end
   endtask

   initial begin
      test_reset();
      test_load_count_down();
      test_start_stop_edges();
      test_reset_mid_run();
`ifndef COUNT_SEQ_AUTO_RELOAD_EN
      test_down_terminal();
      test_up_terminal();
`else
      test_auto_reload();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
